// File: rtl/output_drain_pkg.sv
// Shared types for the output drain: run-state encoding and the stored FIFO entry.
package drain_pkg;

    localparam int DATA_W  = 32;
    localparam int COORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] ch;
    } drain_entry_t;

endpackage

// File: rtl/output_drain_if.sv
// Result input strobe and host-facing output stream of the output drain.
// in_valid is a one-cycle strobe with no back-pressure; out_* is valid/ready:
// a transfer happens on a rising edge with out_valid && out_ready, and the
// head entry holds steady while out_valid is high and out_ready is low.
interface output_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [31:0]           in_x;
    logic [31:0]           in_y;
    logic [31:0]           in_ch;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [31:0]           out_x;
    logic [31:0]           out_y;
    logic [31:0]           out_ch;

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output out_valid, out_data, out_x, out_y, out_ch
    );

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  out_valid, out_data, out_x, out_y, out_ch
    );
endinterface

// File: rtl/output_drain_fifo.sv
// Synchronous FIFO with zeroed storage on reset and a synchronous clear.
// The caller guarantees push only when not full or when popping in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/output_drain.sv
// Captures finished output pixels into a FIFO, streams them to the host,
// checks x/y/ch_out loop order and flags completion once every result is drained.
module output_drain
    import drain_pkg::*;
#(
    parameter int DATA_WIDTH         = DATA_W,
    parameter int FIFO_DEPTH         = 8,
    parameter int AF_MARGIN          = 6,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               arst_n_in,
    input  logic               start,
    output_drain_if.slave      bus,
    output logic               almost_full,
    output logic               overflow,
    output logic               order_error,
    output logic               results_done,
    output logic [CNT_W-1:0]   fifo_count,
    output drain_state_t       o_state
);
    localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
    localparam logic [31:0] X_LAST  = 32'(FEATURE_MAP_WIDTH - 1);
    localparam logic [31:0] Y_LAST  = 32'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [31:0] CH_LAST = 32'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(FIFO_DEPTH - AF_MARGIN);

    drain_state_t     r_state;
    logic [31:0]      r_ex, r_ey, r_ech;
    logic [31:0]      r_drained;
    logic             r_almost_full, r_overflow, r_order_error, r_results_done;

    drain_entry_t     w_wr_entry, w_rd_entry;
    logic             w_full, w_empty, w_push, w_pop, w_drop, w_order_bad;
    logic [CNT_W-1:0] w_count, w_count_next;

    // start discards any same-cycle push or pop
    assign w_pop  = !start && !w_empty && bus.out_ready;
    assign w_push = !start && bus.in_valid && (r_state == RUN) && (!w_full || w_pop);
    assign w_drop = !start && bus.in_valid &&
                    (((r_state == RUN) && w_full && !w_pop) || (r_state == DONE));
    assign w_order_bad = (bus.in_x != r_ex) || (bus.in_y != r_ey) || (bus.in_ch != r_ech);

    always_comb begin
        w_count_next = w_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = w_count + CNT_W'(1);
            2'b01:   w_count_next = w_count - CNT_W'(1);
            default: w_count_next = w_count;
        endcase
    end

    assign w_wr_entry.data = bus.in_data;
    assign w_wr_entry.x    = bus.in_x;
    assign w_wr_entry.y    = bus.in_y;
    assign w_wr_entry.ch   = bus.in_ch;

    sync_fifo #(
        .WIDTH ($bits(drain_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n_in),
        .i_clear (start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state        <= IDLE;
            r_ex           <= '0;
            r_ey           <= '0;
            r_ech          <= '0;
            r_drained      <= '0;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_order_error  <= 1'b0;
            r_results_done <= 1'b0;
        end else if (start) begin
            r_state        <= RUN;
            r_ex           <= '0;
            r_ey           <= '0;
            r_ech          <= '0;
            r_drained      <= '0;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_order_error  <= 1'b0;
            r_results_done <= 1'b0;
        end else begin
            r_almost_full <= (w_count_next >= AF_THRESH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                if (w_order_bad) begin
                    r_order_error <= 1'b1;
                end
                // ch_out fastest, then y, then x
                if (r_ech == CH_LAST) begin
                    r_ech <= '0;
                    if (r_ey == Y_LAST) begin
                        r_ey <= '0;
                        r_ex <= (r_ex == X_LAST) ? '0 : r_ex + 32'd1;
                    end else begin
                        r_ey <= r_ey + 32'd1;
                    end
                end else begin
                    r_ech <= r_ech + 32'd1;
                end
            end
            if (w_pop) begin
                r_drained <= r_drained + 32'd1;
                if ((r_state == RUN) && (r_drained + 32'd1 == TOTAL)) begin
                    r_state        <= DONE;
                    r_results_done <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_rd_entry.data;
    assign bus.out_x     = w_rd_entry.x;
    assign bus.out_y     = w_rd_entry.y;
    assign bus.out_ch    = w_rd_entry.ch;
    assign almost_full   = r_almost_full;
    assign overflow      = r_overflow;
    assign order_error   = r_order_error;
    assign results_done  = r_results_done;
    assign fifo_count    = w_count;
    assign o_state       = r_state;
endmodule

// File: doc/output_drain.md
# output_drain

Downstream stage of the convolution controller. Captures every finished output pixel (data plus x/y/output-channel coordinates) on the controller's `output_valid` strobe into a small FIFO and presents it to the host on a valid/ready stream. Flags upstream congestion early (`almost_full`) so the host can gate operand `valid`, and checks that coordinates arrive in loop order x, y, ch_out (ch_out fastest). Signals completion after `FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS` results have been drained.

## Interface
- `DATA_WIDTH`, 32, width of one output result
- `FIFO_DEPTH`, 8, entries; power of two, >= 8
- `AF_MARGIN`, 6, free-slot threshold for `almost_full`; covers the controller's 5-stage output pipeline plus 1
- `FEATURE_MAP_WIDTH`, 1024, x extent
- `FEATURE_MAP_HEIGHT`, 1024, y extent
- `OUTPUT_NB_CHANNELS`, 64, ch_out extent

Ports:
- `clk` in 1, single clock, rising edge
- `arst_n_in` in 1, reset, asynchronous, active low
- `start` in 1, one-cycle pulse; begins or restarts a run
- `in_valid` in 1, result strobe from controller `output_valid`
- `in_data` in DATA_WIDTH, result value
- `in_x`, `in_y`, `in_ch` in 32 each, result coordinates
- `out_valid` out 1, head entry available
- `out_ready` in 1, host accepts head
- `out_data` out DATA_WIDTH; `out_x`, `out_y`, `out_ch` out 32 each, head entry
- `almost_full` out 1, fifo count >= FIFO_DEPTH - AF_MARGIN
- `overflow` out 1, sticky: a result was dropped
- `order_error` out 1, sticky: accepted coordinates mismatched expected sequence
- `results_done` out 1, level: run complete
- `fifo_count` out $clog2(FIFO_DEPTH)+1, current occupancy

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_valid` ignored, nothing pushed; `start` -> RUN.
- `start` (any state): clears FIFO pointers/count, expected-coordinate counters, drained counter, `overflow`, `order_error`, `results_done`; next state RUN. `start` wins over a simultaneous push/pop (both discarded).
- RUN push: `in_valid` and (not full, or full with pop this cycle) -> entry written. Full without pop -> entry dropped, `overflow` set.
- RUN order check on each accepted push: compare (in_x, in_y, in_ch) to expected (ex, ey, ech); mismatch sets `order_error`, entry still stored. Expected counters advance ech -> wraps at OUTPUT_NB_CHANNELS-1 to 0 and carries to ey -> wraps at FEATURE_MAP_HEIGHT-1 and carries to ex -> wraps at FEATURE_MAP_WIDTH-1.
- Pop: `out_valid && out_ready`. Drained counter (32 bit) increments per pop; pop making it equal TOTAL -> DONE.
- DONE: `results_done`=1; `in_valid` dropped and sets `overflow`; `start` -> RUN.
- `in_valid` in IDLE is not an error.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, storage zeroed.
- Push-to-`out_valid` latency 1 cycle; no combinational in->out bypass.
- Simultaneous push and pop when empty: head from previous cycle popped only if valid; new entry visible next cycle.
- `out_*` stable while `out_valid && !out_ready`.
- `almost_full`, `fifo_count` registered, reflect occupancy after the current edge.
- `results_done` rises the cycle after the final pop.
- Reset asserted mid-run: immediate return to reset values; FIFO contents lost.

## Structure
- Shared package `drain_pkg`: `drain_state_t` enum {IDLE, RUN, DONE}; `drain_entry_t` packed struct {data, x, y, ch}.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count, async active-low reset); FSM, order checker, counters in `output_drain`.

## Test plan
- Reset then `start`, 4 pushes (data 1..4, coords (0,0,0)..(0,0,3)), `out_ready`=1 -> outputs 1..4 in order, each 1 cycle after push, `order_error`=0.
- FIFO_DEPTH=8, `out_ready`=0, 9 pushes -> `almost_full` after push 2, `fifo_count`=8, 9th dropped, `overflow`=1, drain yields first 8.
- Full FIFO, push and pop same cycle -> push accepted, count stays 8, `overflow`=0.
- Push coords (0,0,1) as first result -> `order_error`=1 sticky until `start`.
- W=H=2, OUT_CH=2: 8 ordered results with random `out_ready` -> `results_done`=1 cycle after 8th pop; extra push -> `overflow`=1.
- Assert `arst_n_in` with 3 entries queued -> `out_valid`=0, `fifo_count`=0 immediately; `start` restarts cleanly.
